// File: rtl/esp_uart_pkg.sv
// Shared constants for the ESP32 UartLite reader: register map,
// STAT bit positions, AXI response codes, FSM encoding, error bundle.
package esp_uart_pkg;

  localparam logic [3:0] UART_RX_FIFO = 4'h0;
  localparam logic [3:0] UART_TX_FIFO = 4'h4;
  localparam logic [3:0] UART_STAT    = 4'h8;
  localparam logic [3:0] UART_CTRL    = 4'hC;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_FRAME    = 6;
  localparam int STAT_PARITY   = 7;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STAT_AR = 3'd1;
  localparam logic [2:0] ST_STAT_R  = 3'd2;
  localparam logic [2:0] ST_DATA_AR = 3'd3;
  localparam logic [2:0] ST_DATA_R  = 3'd4;

  typedef struct packed {
    logic resp;
    logic parity;
    logic frame;
    logic overrun;
  } rx_err_t;

  function automatic rx_err_t stat_errs(
    input logic [31:0] stat
  );
    rx_err_t e;
    e.resp    = 1'b0;
    e.parity  = stat[STAT_PARITY];
    e.frame   = stat[STAT_FRAME];
    e.overrun = stat[STAT_OVERRUN];
    return e;
  endfunction

endpackage

// File: rtl/esp_uart_rx_reader_if.sv
// AXI4-Lite read channel (AR + R) between reader and UartLite.
// master: reader side; slave: UartLite / bus model side.
interface esp_uart_rx_reader_if;

  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr,
    output arvalid,
    output rready,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid
  );

  modport slave (
    input  araddr,
    input  arvalid,
    input  rready,
    output arready,
    output rdata,
    output rresp,
    output rvalid
  );

endinterface

// File: rtl/esp_byte_fifo.sv
// First-word-fall-through byte FIFO; DEPTH must be a power of two.
// Ports: push/din, pop/dout, full, empty, count; async active-high rst.
module esp_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Idle head reads as zero so data is clean whenever valid is low.
  assign dout = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/esp_uart_rx_reader.sv
// Polls UartLite STAT over AXI-Lite reads, drains RX_FIFO into a byte stream.
// Ports: clk/rst, axi (AR/R master), data/valid/ready stream, sticky err_* + err_clr.
module esp_uart_rx_reader
  import esp_uart_pkg::*;
#(
  parameter int POLL_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  esp_uart_rx_reader_if.master axi,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  input  logic        err_clr,
  output logic        err_overrun,
  output logic        err_frame,
  output logic        err_parity,
  output logic        err_resp
);

  localparam int TW = $clog2(POLL_DIV + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_LOAD = TW'(POLL_DIV - 1);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          ar_valid;
  logic [3:0]    ar_addr;

  logic          in_stat_r;
  logic          in_data_r;
  logic          r_ok;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  rx_err_t       err_q;
  rx_err_t       err_set;
  rx_err_t       err_hold;

  logic          unused;

  assign in_stat_r = state == ST_STAT_R;
  assign in_data_r = state == ST_DATA_R;
  assign r_ok      = axi.rresp == AXI_OKAY;

  assign axi.araddr  = ar_addr;
  assign axi.arvalid = ar_valid;
  assign axi.rready  = in_stat_r | in_data_r;

  // Space was confirmed at the STAT decision and only pops happen since,
  // so this push cannot be refused.
  assign push  = in_data_r && axi.rvalid && r_ok;
  assign valid = !fifo_empty;
  assign pop   = valid && ready;

  esp_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (axi.rdata[7:0]),
    .pop   (pop),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (!fifo_full) begin
            state    <= ST_STAT_AR;
            ar_valid <= 1'b1;
            ar_addr  <= UART_STAT;
          end
        end
        ST_STAT_AR: begin
          if (axi.arready) begin
            ar_valid <= 1'b0;
            state    <= ST_STAT_R;
          end
        end
        ST_STAT_R: begin
          if (axi.rvalid) begin
            if (r_ok && axi.rdata[STAT_RX_VALID]
                && !fifo_full) begin
              state    <= ST_DATA_AR;
              ar_valid <= 1'b1;
              ar_addr  <= UART_RX_FIFO;
            end else begin
              timer <= T_LOAD;
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA_AR: begin
          if (axi.arready) begin
            ar_valid <= 1'b0;
            state    <= ST_DATA_R;
          end
        end
        ST_DATA_R: begin
          // Straight back to STAT: burst-drain without the poll wait.
          if (axi.rvalid) begin
            state    <= ST_STAT_AR;
            ar_valid <= 1'b1;
            ar_addr  <= UART_STAT;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ar_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_set = '0;
    if (in_stat_r && axi.rvalid) begin
      err_set = stat_errs(axi.rdata);
    end
    if ((in_stat_r || in_data_r)
        && axi.rvalid && !r_ok) begin
      err_set.resp = 1'b1;
    end
  end

  // A new error in the clearing cycle survives.
  assign err_hold = err_clr ? '0 : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= rx_err_t'(err_hold | err_set);
    end
  end

  assign err_overrun = err_q.overrun;
  assign err_frame   = err_q.frame;
  assign err_parity  = err_q.parity;
  assign err_resp    = err_q.resp;

  assign unused = ^{axi.rdata[31:8], fifo_count};

endmodule

// File: tb/tb_esp_uart_rx_reader.sv
// Bench for esp_uart_rx_reader: AXI-Lite UartLite model with a byte queue,
// stream scoreboard, protocol monitors, error-flag vector table.
module tb_esp_uart_rx_reader;
  import esp_uart_pkg::*;

  localparam int POLL_DIV = 16;
  localparam int DEPTH    = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       err_clr;
  logic       err_overrun;
  logic       err_frame;
  logic       err_parity;
  logic       err_resp;

  esp_uart_rx_reader_if bus ();

  esp_uart_rx_reader #(
    .POLL_DIV   (POLL_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (bus),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .err_clr     (err_clr),
    .err_overrun (err_overrun),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_resp    (err_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // UartLite model knobs and state
  logic [7:0] uart_q [$];
  logic [7:0] exp_q  [$];
  logic [2:0] stat_err;
  logic [1:0] stat_resp;
  logic [1:0] data_resp;
  bit         rand_mode;
  bit         slow_data;
  bit         coincide_clr;
  bit         clr_req;
  bit         in_data_r;

  int cyc;
  int stat_done;
  int data_reads;
  int ar_count;
  int data_ar;
  int last_stat;
  int prev_stat;

  bit         have_ar;
  bit         ar_started;
  int         ar_cnt;
  int         r_cnt;
  logic [3:0] pend_addr;
  logic       s_arv;
  logic       s_ardy;
  logic [3:0] s_addr;
  logic       s_rv;
  logic       s_rr;
  logic [7:0] b;

  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    err_clr     = 1'b0;
    have_ar = 0; ar_started = 0;
    s_arv = 0; s_ardy = 0; s_rv = 0; s_rr = 0;
    s_addr = '0; pend_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      err_clr = 1'b0;
      if (rst) begin
        have_ar = 0; ar_started = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
        s_arv = 0; s_ardy = 0; s_rv = 0; s_rr = 0;
        in_data_r = 0;
        continue;
      end
      if (s_rv && s_rr) begin
        bus.rvalid = 1'b0;
        have_ar = 0;
        if (pend_addr == UART_STAT) begin
          stat_done++;
        end else begin
          data_reads++;
          if (uart_q.size() > 0) begin
            b = uart_q.pop_front();
            if (bus.rresp == AXI_OKAY) begin
              exp_q.push_back(b);
              chk("latency_valid", valid, 1);
            end
          end
        end
      end
      if (s_arv && s_ardy) begin
        chk("ar_deassert", bus.arvalid, 0);
        have_ar = 1;
        pend_addr = s_addr;
        ar_started = 0;
        bus.arready = 1'b0;
        ar_count++;
        if (s_addr == UART_STAT) begin
          prev_stat = last_stat;
          last_stat = cyc;
        end else begin
          data_ar++;
        end
        if (rand_mode)
          r_cnt = $urandom_range(0, 5);
        else
          r_cnt = (s_addr == UART_RX_FIFO && slow_data) ? 5 : 0;
      end else if (s_arv) begin
        chk("ar_hold", {bus.arvalid, bus.araddr},
            {1'b1, s_addr});
      end
      if (bus.arvalid)
        chk("one_outstanding", have_ar, 0);
      chk("rready_state", bus.rready, have_ar);
      if (bus.arvalid && !have_ar && !bus.arready) begin
        if (!ar_started) begin
          ar_started = 1;
          ar_cnt = rand_mode ? $urandom_range(0, 5) : 1;
        end
        if (ar_cnt == 0) bus.arready = 1'b1;
        else ar_cnt--;
      end
      if (have_ar && !bus.rvalid) begin
        if (r_cnt == 0) begin
          bus.rvalid = 1'b1;
          if (pend_addr == UART_STAT) begin
            bus.rdata = {24'h0, stat_err, 4'h0,
                         uart_q.size() > 0};
            bus.rresp = stat_resp;
            if (coincide_clr) err_clr = 1'b1;
          end else begin
            bus.rdata = {24'h0,
              uart_q.size() > 0 ? uart_q[0] : 8'h00};
            bus.rresp = data_resp;
          end
        end else begin
          r_cnt--;
        end
      end
      if (clr_req) begin
        err_clr = 1'b1;
        clr_req = 0;
      end
      in_data_r = have_ar && pend_addr == UART_RX_FIFO;
      s_arv  = bus.arvalid;
      s_ardy = bus.arready;
      s_addr = bus.araddr;
      s_rv   = bus.rvalid;
      s_rr   = bus.rready;
    end
  end

  // Stream scoreboard and hold-stability monitor
  logic       pv;
  logic       pr;
  logic [7:0] pd;
  initial begin
    pv = 0; pr = 0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 0; pr = 0;
        continue;
      end
      if (pv && !pr)
        chk("stream_hold", {valid, data}, {1'b1, pd});
      if (valid && ready) begin
        if (exp_q.size() == 0)
          chk("stream_unexpected", {1'b1, data}, 0);
        else
          chk("stream_data", data, exp_q.pop_front());
      end
      pv = valid; pr = ready; pd = data;
    end
  end

  task automatic wait_drain(input string name,
                            input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      done = uart_q.size() == 0 && exp_q.size() == 0
             && !valid;
    end
    chk(name, done, 1);
  endtask

  typedef struct {
    logic [2:0] stat;
    int         mode;
    logic [2:0] exp;
  } err_vec_t;

  err_vec_t tbl [6];
  int base;
  int ar0;
  bit found;

  initial begin
    tbl[0] = '{3'b111, 0, 3'b111};
    tbl[1] = '{3'b000, 1, 3'b000};
    tbl[2] = '{3'b001, 2, 3'b001};
    tbl[3] = '{3'b010, 0, 3'b011};
    tbl[4] = '{3'b100, 0, 3'b111};
    tbl[5] = '{3'b000, 2, 3'b000};

    checks = 0; failures = 0;
    stat_err = 0; stat_resp = 0; data_resp = 0;
    rand_mode = 0; slow_data = 0;
    coincide_clr = 0; clr_req = 0;
    rst = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_bus",
        {bus.arvalid, bus.rready, bus.araddr}, 0);
    chk("reset_stream", {valid, data}, 0);
    chk("reset_err", {err_resp, err_parity,
                      err_frame, err_overrun}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle polling with an empty UART
    repeat (70) @(negedge clk);
    #2;
    chk("idle_no_data_ar", data_ar, 0);
    chk("idle_valid", valid, 0);
    chk("idle_polls", stat_done >= 3, 1);
    chk("poll_period", last_stat - prev_stat,
        POLL_DIV + 3);

    // Burst of three bytes
    ready = 1'b1;
    base = data_reads;
    uart_q.push_back(8'h41);
    uart_q.push_back(8'h54);
    uart_q.push_back(8'h0D);
    wait_drain("burst_drain", 500);
    chk("burst_reads", data_reads - base, 3);

    // Backpressure: 6 bytes, FIFO holds 4
    @(negedge clk);
    ready = 1'b0;
    base = data_reads;
    for (int i = 0; i < 6; i++)
      uart_q.push_back(8'(8'h80 + i));
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = (data_reads - base) >= 4;
    end
    chk("bp_fill", found, 1);
    repeat (20) @(negedge clk);
    ar0 = ar_count;
    repeat (60) @(negedge clk);
    #2;
    chk("bp_no_ar", ar_count - ar0, 0);
    chk("bp_reads", data_reads - base, 4);
    chk("bp_valid", valid, 1);
    @(negedge clk);
    ready = 1'b1;
    wait_drain("bp_drain", 500);
    chk("bp_total", data_reads - base, 6);

    // Random bus delays and random ready
    rand_mode = 1;
    base = data_reads;
    for (int i = 0; i < 12; i++)
      uart_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
      if (uart_q.size() == 0 && exp_q.size() == 0)
        break;
    end
    @(negedge clk);
    ready = 1'b1;
    wait_drain("rand_drain", 1000);
    chk("rand_reads", data_reads - base, 12);
    rand_mode = 0;
    repeat (30) @(negedge clk);

    // Sticky error vectors
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      stat_err = tbl[k].stat;
      coincide_clr = tbl[k].mode == 2;
      if (tbl[k].mode == 1) clr_req = 1;
      if (k == 0) uart_q.push_back(8'h7E);
      base = stat_done;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        #2;
        found = stat_done >= base + 2;
      end
      chk("err_wait", found, 1);
      chk($sformatf("err_vec%0d", k),
          {err_parity, err_frame, err_overrun},
          tbl[k].exp);
      coincide_clr = 0;
    end
    stat_err = 0;
    wait_drain("err_byte_drain", 300);
    chk("err_resp_clean", err_resp, 0);

    // Error response on a data read
    @(negedge clk);
    data_resp = 2'b10;
    base = data_reads;
    uart_q.push_back(8'hAA);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = data_reads > base;
    end
    chk("resp_read", found, 1);
    data_resp = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    chk("resp_flag", err_resp, 1);
    chk("resp_no_push", {valid, 8'(exp_q.size())}, 0);

    // Reset in the middle of a data read
    slow_data = 1;
    base = data_reads;
    uart_q.push_back(8'h5A);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #2;
      found = in_data_r;
    end
    chk("reach_data_r", found, 1);
    rst = 1'b1;
    #1;
    chk("midrst_bus",
        {bus.arvalid, bus.rready, bus.araddr}, 0);
    chk("midrst_stream", {valid, data}, 0);
    chk("midrst_err", {err_resp, err_parity,
                       err_frame, err_overrun}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    slow_data = 0;
    wait_drain("post_rst_drain", 300);
    chk("post_rst_reads", data_reads - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/esp_uart_rx_reader.md
Name: esp_uart_rx_reader

Overview:
- AXI4-Lite read-channel master that polls the AXI UartLite status register and drains its RX FIFO.
- Delivers received ESP32 bytes on a valid/ready byte stream.
- Counterpart to the existing AXI-Lite write-side transmit path; shares the same axi_uartlite_0 instance through its AR/R channels.
- Latches UART line errors as sticky flags.

Parameters:
- POLL_DIV, 16, idle cycles between status polls when the RX FIFO is empty (≥1).
- FIFO_DEPTH, 4, output byte buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- araddr  out  4  AXI read address (UartLite register offset)
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- data  out  8  received byte (FIFO head)
- valid  out  1  data valid
- ready  in  1  downstream accepts data
- err_clr  in  1  clears all sticky error flags
- err_overrun  out  1  sticky, STAT bit5 seen set
- err_frame  out  1  sticky, STAT bit6 seen set
- err_parity  out  1  sticky, STAT bit7 seen set
- err_resp  out  1  sticky, rresp != 2'b00 on any read

Behaviour:
- Reset values: arvalid=0, rready=0, araddr=0, valid=0, data=0, all err_*=0, FIFO empty, poll timer=0, state IDLE. The first poll may start on the first cycle after reset.
- Register offsets: RX_FIFO=4'h0, STAT=4'h8.
- States:
  - IDLE: stay while the poll timer is non-zero (decrement each cycle) or the FIFO is full. Otherwise → STAT_AR.
  - STAT_AR: araddr=STAT, arvalid=1. On arready → STAT_R.
  - STAT_R: rready=1. On rvalid:
    - Merge rdata[7:5] into the sticky error flags.
    - If rresp != 0: set err_resp, load timer = POLL_DIV-1, → IDLE.
    - Else if rdata[0]=1 and FIFO not full → DATA_AR.
    - Else: load timer = POLL_DIV-1, → IDLE.
  - DATA_AR: araddr=RX_FIFO, arvalid=1. On arready → DATA_R.
  - DATA_R: rready=1. On rvalid:
    - If rresp=0: push rdata[7:0] into the FIFO.
    - Else: discard the byte and set err_resp.
    - → STAT_AR immediately, with no timer wait, to burst-drain the RX FIFO.
- AXI rules:
  - Only one read is outstanding at a time.
  - araddr/arvalid are driven from registers, held stable until the arready handshake, and deasserted the cycle after it.
  - arvalid never depends combinationally on arready.
  - rready is high only in the *_R states.
- No-drop guarantee:
  - RX_FIFO is read only when FIFO space is confirmed at the STAT_R decision.
  - Pops only free space, so the push in DATA_R always succeeds.
  - A full FIFO stalls polling in IDLE.
- Output stream:
  - First-word fall-through: valid = !empty, data = head entry.
  - Pop on valid && ready.
  - data/valid stay stable while valid && !ready.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
- Latency: a byte captured on the DATA_R rvalid edge appears on data/valid the next cycle.
- Sticky flags: set on any observed bit and cleared by err_clr. If set and clear coincide, set wins.
- Reset mid-transaction:
  - Everything returns to the reset values; any in-flight AXI read is abandoned.
  - The UartLite is reset by the same rst (aresetn = !rst), so the bus stays consistent.
- Timer width: $clog2(POLL_DIV+1). With POLL_DIV=1, polls are back-to-back.

Decomposition:
- Package esp_uart_pkg:
  - Register offsets UART_RX_FIFO=4'h0, UART_TX_FIFO=4'h4, UART_STAT=4'h8, UART_CTRL=4'hC.
  - STAT bit indices: RX_VALID=0, RX_FULL=1, TX_EMPTY=2, TX_FULL=3, OVERRUN=5, FRAME=6, PARITY=7.
  - AXI response constant OKAY=2'b00.
  - Reader state encoding.
- Sub-module esp_byte_fifo:
  - Parameterized FWFT synchronous FIFO with push/pop/full/empty/count.
  - Same clk and async active-high rst.

Test Plan:
- Reset, STAT model returns 32'h00 → arvalid pulses with araddr=8 every POLL_DIV+3 cycles, araddr=0 never issued, valid=0.
- STAT bit0 set for 3 reads, RX returns 8'h41, 8'h54, 8'h0D, ready=1 → three back-to-back STAT/DATA pairs, then a return to the timer. Stream outputs 41,54,0D in order; data valid one cycle after each DATA_R handshake.
- ready=0 with the UART model holding 6 bytes, FIFO_DEPTH=4 → exactly 4 RX_FIFO reads, then no AR issued while full. Raising ready drains 4 bytes, the remaining 2 are read and output, and no byte is lost or duplicated.
- Random arready/rvalid delays of 0–5 cycles → araddr/arvalid stable until handshake, never more than one outstanding read, byte order intact.
- STAT returns 32'hE1 (errors + data) → err_overrun/frame/parity=1 and the byte is still read. err_clr pulse clears them. err_clr coincident with another 32'h20 status leaves err_overrun=1.
- rresp=2'b10 on a DATA read → byte not pushed, err_resp=1. Assert rst mid-DATA_R → all outputs return to the reset values in the same cycle, then polling resumes normally.
